// File: rtl/button_events.sv
// button_events: classifies a debounced button level into one-cycle pulses.
// Events: press, release, click, double-click, long-press, auto-repeat.
//
// Parameters:
//   CLOCK_RATE_HZ - system clock frequency
//   TICK_RATE_HZ  - rate of the internal time tick (1000 -> 1 ms units)
//   LONG_MS       - hold time in ticks before long-press (1..65534)
//   DOUBLE_MS     - double-click window in ticks after a short release
//   REPEAT_MS     - auto-repeat period in ticks while long-held
//
// Ports:
//   i_clk     - system clock
//   i_rst_n   - asynchronous active-low reset
//   i_btn     - debounced button level, 1 = pressed
//   o_press   - pulse on each 0->1 edge
//   o_release - pulse on each 1->0 edge
//   o_click   - pulse when a single short press is confirmed
//   o_dclick  - pulse on a second press inside the double-click window
//   o_long    - pulse when a hold reaches LONG_MS
//   o_repeat  - periodic pulse while held after long-press
//
// Build option: define BUTTON_EVENTS_AUTOREPEAT_EN to enable auto-repeat;
// without it o_repeat is tied to 0.

module button_events #(
    parameter int CLOCK_RATE_HZ = 16_000_000,
    parameter int TICK_RATE_HZ  = 1000,
    parameter int LONG_MS       = 1000,
    parameter int DOUBLE_MS     = 300,
    parameter int REPEAT_MS     = 200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_dclick,
    output logic o_long,
    output logic o_repeat
);

    localparam int DIV = CLOCK_RATE_HZ / TICK_RATE_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [15:0] LONG_T   = 16'(LONG_MS);
    localparam logic [15:0] DOUBLE_T = 16'(DOUBLE_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG,
        S_WAIT2,
        S_PRESSED2
    } state_t;

    state_t state_q, state_d;

    logic          btn_q;
    logic          rise, fall;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [15:0]   ms_cnt;

    logic press_d, release_d, click_d, dclick_d, long_d;

    assign rise = i_btn & ~btn_q;
    assign fall = ~i_btn & btn_q;
    assign tick = (pre_cnt == PRE_MAX);

    // Free-running prescaler; never re-phased by button activity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Ticks since the last edge, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ms_cnt <= '0;
        end else if (rise || fall) begin
            ms_cnt <= '0;
        end else if (tick && ms_cnt != 16'hFFFF) begin
            ms_cnt <= ms_cnt + 16'd1;
        end
    end

    // Edges are tested before thresholds so an edge always wins a tie.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_WAIT2;
                end else if (tick && ms_cnt == LONG_T) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            S_LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    press_d  = 1'b1;
                    dclick_d = 1'b1;
                    state_d  = S_PRESSED2;
                end else if (tick && ms_cnt == DOUBLE_T) begin
                    click_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PRESSED2: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (tick && ms_cnt == LONG_T) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            btn_q     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_click   <= 1'b0;
            o_dclick  <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= i_btn;
            o_press   <= press_d;
            o_release <= release_d;
            o_click   <= click_d;
            o_dclick  <= dclick_d;
            o_long    <= long_d;
        end
    end

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_MS - 1);

    logic [15:0] rep_cnt;

    // Held at zero outside LONG, so it is clear on every entry.
    // A release in LONG suppresses a coincident repeat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt  <= '0;
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= 1'b0;
            if (state_q != S_LONG) begin
                rep_cnt <= '0;
            end else if (tick && !fall) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt  <= '0;
                    o_repeat <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: randomized self-checking bench for button_events.
// Reference model works on edge indices, tick instants and tick counts.

module tb_button_events;

    localparam int CLK_HZ = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int LONG_MS = 20;
    localparam int DOUBLE_MS = 5;
    localparam int REPEAT_MS = 4;

    logic i_clk, i_rst_n, i_btn;
    logic o_press, o_release, o_click, o_dclick, o_long, o_repeat;
    logic [5:0] obs;
    logic [5:0] exp_v;

    int checks = 0;
    int errors = 0;

    assign obs = {o_press, o_release, o_click, o_dclick, o_long, o_repeat};

    button_events #(
        .CLOCK_RATE_HZ(CLK_HZ),
        .TICK_RATE_HZ(TICK_HZ),
        .LONG_MS(LONG_MS),
        .DOUBLE_MS(DOUBLE_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_btn(i_btn),
        .o_press(o_press),
        .o_release(o_release),
        .o_click(o_click),
        .o_dclick(o_dclick),
        .o_long(o_long),
        .o_repeat(o_repeat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model state: k is the index of the next clock edge since reset release.
    int k;
    logic bp;
    bit held, long_done, second, waiting;
    int since_edge, since_long;

    task automatic model_reset();
        k = 0;
        bp = 1'b0;
        held = 0;
        long_done = 0;
        second = 0;
        waiting = 0;
        since_edge = 0;
        since_long = 0;
        exp_v = '0;
    endtask

    // exp_v bits: 5 press, 4 release, 3 click, 2 dclick, 1 long, 0 repeat
    task automatic model_step(input logic b);
        bit tk;
        tk = (k % DIV) == DIV - 1;
        exp_v = '0;
        if (b && !bp) begin
            exp_v[5] = 1'b1;
            if (waiting) begin
                exp_v[2] = 1'b1;
                second = 1;
            end else begin
                second = 0;
            end
            waiting = 0;
            held = 1;
            long_done = 0;
            since_edge = 0;
        end else if (!b && bp) begin
            exp_v[4] = 1'b1;
            waiting = held && !long_done && !second;
            held = 0;
            long_done = 0;
            since_edge = 0;
        end else if (tk) begin
            if (held && !long_done && since_edge == LONG_MS) begin
                exp_v[1] = 1'b1;
                long_done = 1;
                since_long = 0;
            end else if (held && long_done) begin
                since_long++;
                if (since_long == REPEAT_MS) begin
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                    exp_v[0] = 1'b1;
`endif
                    since_long = 0;
                end
            end else if (waiting && since_edge == DOUBLE_MS) begin
                exp_v[3] = 1'b1;
                waiting = 0;
            end
            if (since_edge < 65535) since_edge++;
        end
        bp = b;
        k++;
    endtask

    task automatic step(input logic b);
        i_btn = b;
        @(posedge i_clk);
        #1;
        model_step(b);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold got %b want %b", obs, 6'b0);
            end
        end
        i_rst_n = 1'b1;
        model_reset();
        step(1'b1);
        checks++;
        if (o_press !== 1'b1 || obs !== exp_v) begin
            errors++;
            $display("FAIL reset_first_press got %b want %b", obs, exp_v);
        end
        step(1'b1);
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_press_once got %b want %b", obs, 6'b0);
        end
        for (int i = 0; i < 80; i++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_tail k=%0d got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_click();
        int hi, rel_i, clk_i, clicks, bad;
        hi = $urandom_range(40, 20);
        rel_i = -1;
        clk_i = -1;
        clicks = 0;
        bad = 0;
        for (int i = 0; i < hi + 90; i++) begin
            step(i < hi);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL click k=%0d got %b want %b", k, obs, exp_v);
            end
            if (o_release) rel_i = i;
            if (o_click) begin
                clicks++;
                clk_i = i;
            end
            if (o_dclick || o_long) bad++;
        end
        checks++;
        if (clicks != 1 || bad != 0) begin
            errors++;
            $display("FAIL click_count got %0d/%0d want 1/0", clicks, bad);
        end
        checks++;
        if (clk_i - rel_i < 40 || clk_i - rel_i > 60) begin
            errors++;
            $display("FAIL click_latency got %0d want 40..60", clk_i - rel_i);
        end
    endtask

    task automatic test_double_click();
        int h1, lo, h2, n, dcl, dcp, clicks;
        h1 = $urandom_range(40, 20);
        lo = $urandom_range(35, 10);
        h2 = $urandom_range(40, 20);
        n = h1 + lo + h2 + 90;
        dcl = 0;
        dcp = 0;
        clicks = 0;
        for (int i = 0; i < n; i++) begin
            step((i < h1) || (i >= h1 + lo && i < h1 + lo + h2));
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL dclick k=%0d got %b want %b", k, obs, exp_v);
            end
            if (o_dclick) dcl++;
            if (o_dclick && o_press) dcp++;
            if (o_click) clicks++;
        end
        checks++;
        if (dcl != 1 || dcp != 1 || clicks != 0) begin
            errors++;
            $display("FAIL dclick_count got %0d/%0d/%0d want 1/1/0",
                     dcl, dcp, clicks);
        end
    endtask

    task automatic test_long_repeat();
        int long_i, longs, reps, rels, clicks, want_reps;
        long_i = -1;
        longs = 0;
        reps = 0;
        rels = 0;
        clicks = 0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        want_reps = 4;
`else
        want_reps = 0;
`endif
        for (int i = 0; i < 460; i++) begin
            step(i < 400);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL long k=%0d got %b want %b", k, obs, exp_v);
            end
            if (o_long) begin
                longs++;
                long_i = i;
            end
            if (o_repeat) reps++;
            if (o_release) rels++;
            if (o_click || o_dclick) clicks++;
        end
        checks++;
        if (longs != 1 || long_i < 190 || long_i > 215) begin
            errors++;
            $display("FAIL long_time got %0d@%0d want 1@190..215",
                     longs, long_i);
        end
        checks++;
        if (reps != want_reps || rels != 1 || clicks != 0) begin
            errors++;
            $display("FAIL long_counts got %0d/%0d/%0d want %0d/1/0",
                     reps, rels, clicks, want_reps);
        end
    endtask

    // Second press lands on the very edge where the click window expires.
    task automatic test_back_to_back();
        int f, j, cnt;
        for (int i = 0; i < 25; i++) begin
            step(1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tie_hold k=%0d got %b want %b", k, obs, exp_v);
            end
        end
        step(1'b0);
        f = k - 1;
        j = f;
        cnt = 0;
        while (cnt < DOUBLE_MS + 1) begin
            j++;
            if (j % DIV == DIV - 1) cnt++;
        end
        while (k < j) begin
            step(1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tie_gap k=%0d got %b want %b", k, obs, exp_v);
            end
        end
        step(1'b1);
        checks++;
        if (o_dclick !== 1'b1 || o_click !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("FAIL tie_edge got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 110; i++) begin
            step(i < 30);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tie_tail k=%0d got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        int len;
        lvl = 1'b0;
        for (int s = 0; s < 40; s++) begin
            lvl = ~lvl;
            len = $urandom_range(260, 1);
            for (int i = 0; i < len; i++) begin
                step(lvl);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL random k=%0d got %b want %b",
                             k, obs, exp_v);
                end
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_tail k=%0d got %b want %b",
                         k, obs, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        int clicks;
        clicks = 0;
        for (int i = 0; i < 45; i++) begin
            step(i < 25);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midrst_pre k=%0d got %b want %b",
                         k, obs, exp_v);
            end
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async got %b want %b", obs, 6'b0);
        end
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midrst_post k=%0d got %b want %b",
                         k, obs, exp_v);
            end
            if (o_click || o_release || o_long) clicks++;
        end
        checks++;
        if (clicks != 0) begin
            errors++;
            $display("FAIL midrst_silent got %0d want 0", clicks);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_btn = 1'b0;
        model_reset();
        test_reset();
        test_single_click();
        test_double_click();
        test_long_repeat();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
